// File: rtl/stream_to_axi_dma.sv
// stream_to_axi_dma
// Collects a 32-bit Avalon-ST word stream into an internal FIFO and writes it
// into a circular frame region in memory as fixed-length AXI4 INCR bursts.
// A small Avalon-MM register file configures the region and reports status.
module stream_to_axi_dma #(
    parameter int ADDR_WIDTH         = 24,
    parameter int BURST_SIZE         = 64,
    parameter int MAX_OUTSTANDING_TR = 2,
    parameter int FIFO_DEPTH         = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    // stream input
    input  logic [31:0]           st_data,
    input  logic                  st_valid,
    input  logic                  st_startofpacket,
    input  logic                  st_endofpacket,
    output logic                  st_ready,
    // AXI4 write address channel
    output logic [3:0]            mst_axi_awid,
    output logic [ADDR_WIDTH-1:0] mst_axi_awaddr,
    output logic [7:0]            mst_axi_awlen,
    output logic [2:0]            mst_axi_awsize,
    output logic [1:0]            mst_axi_awburst,
    output logic                  mst_axi_awlock,
    output logic [3:0]            mst_axi_awcache,
    output logic [2:0]            mst_axi_awprot,
    output logic [3:0]            mst_axi_awqos,
    output logic                  mst_axi_awvalid,
    input  logic                  mst_axi_awready,
    // AXI4 write data channel
    output logic [31:0]           mst_axi_wdata,
    output logic [3:0]            mst_axi_wstrb,
    output logic                  mst_axi_wlast,
    output logic                  mst_axi_wvalid,
    input  logic                  mst_axi_wready,
    // AXI4 write response channel
    input  logic [3:0]            mst_axi_bid,
    input  logic [1:0]            mst_axi_bresp,
    input  logic                  mst_axi_bvalid,
    output logic                  mst_axi_bready,
    // Avalon-MM control slave
    input  logic [4:0]            ctrl_address,
    input  logic                  ctrl_read,
    output logic [31:0]           ctrl_readdata,
    output logic [1:0]            ctrl_response,
    input  logic                  ctrl_write,
    input  logic [31:0]           ctrl_writedata,
    input  logic [3:0]            ctrl_byteenable,
    output logic                  ctrl_waitrequest
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING_TR + 1);
    localparam logic [CNT_W-1:0]      BURST_CNT   = CNT_W'(BURST_SIZE);
    localparam logic [CNT_W-1:0]      FIFO_FULL   = CNT_W'(FIFO_DEPTH);
    localparam logic [7:0]            LAST_BEAT   = 8'(BURST_SIZE - 1);
    localparam logic [29:0]           BURST_WORDS = 30'(BURST_SIZE);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_SIZE * 4);
    localparam logic [OUT_W-1:0]      MAX_OUT     = OUT_W'(MAX_OUTSTANDING_TR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AW   = 2'd1,
        S_DATA = 2'd2
    } state_t;

    state_t                  state_r, state_next_s;
    logic [ADDR_WIDTH-1:0]   start_addr_r, curr_addr_r;
    logic [29:0]             words_number_r, frame_cnt_r, issued_words_r, word_idx_s;
    logic                    enable_r, draining_r, synced_r;
    logic                    err_sop_r, err_eop_r, err_bresp_r;
    logic [OUT_W-1:0]        outstanding_r;
    logic [7:0]              beat_r;
    logic [31:0]             fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]        fifo_cnt_r;
    logic                    rd_phase_r;
    logic [31:0]             readdata_r, rd_mux_s;
    logic                    awvalid_s, wvalid_s, st_ready_s, busy_s;
    logic                    wr_start_s, wr_words_s, wr_ctrl_s, wr_status_s;
    logic                    enable_rise_s, enable_fall_s;
    logic                    st_fire_s, push_s, pop_s, aw_fire_s, w_fire_s, w_last_fire_s;
    logic                    flush_s, drain_done_s, sop_err_s, eop_err_s, bresp_err_s;
    logic                    unused_ok_s;

    assign unused_ok_s = ^{ctrl_byteenable, mst_axi_bid, ctrl_writedata};

    // control-bus write decode and enable edges
    assign wr_start_s    = ctrl_write && (ctrl_address == 5'h00);
    assign wr_words_s    = ctrl_write && (ctrl_address == 5'h04);
    assign wr_ctrl_s     = ctrl_write && (ctrl_address == 5'h08);
    assign wr_status_s   = ctrl_write && (ctrl_address == 5'h0C);
    assign enable_rise_s = wr_ctrl_s &&  ctrl_writedata[0] && !enable_r;
    assign enable_fall_s = wr_ctrl_s && !ctrl_writedata[0] &&  enable_r;

    // handshakes
    assign st_ready_s    = enable_r && !draining_r && (fifo_cnt_r != FIFO_FULL);
    assign st_fire_s     = st_valid && st_ready_s;
    assign push_s        = st_fire_s && (synced_r || st_startofpacket);
    assign aw_fire_s     = (state_r == S_AW) && mst_axi_awready;
    assign w_fire_s      = (state_r == S_DATA) && mst_axi_wready;
    assign pop_s         = w_fire_s;
    assign w_last_fire_s = w_fire_s && (beat_r == LAST_BEAT);

    // a disabled block throws away any partial burst once the FSM is idle,
    // and returns to its start-of-frame state when nothing is left in flight
    assign flush_s      = draining_r && (state_r == S_IDLE) && (fifo_cnt_r < BURST_CNT);
    assign drain_done_s = draining_r && (state_r == S_IDLE) && (fifo_cnt_r == {CNT_W{1'b0}})
                          && (outstanding_r == {OUT_W{1'b0}});

    // frame position of the word being accepted (the sync word is word 0)
    assign word_idx_s  = synced_r ? frame_cnt_r : 30'd0;
    assign sop_err_s   = push_s && st_startofpacket && (word_idx_s != 30'd0);
    assign eop_err_s   = push_s && st_endofpacket && (word_idx_s != (words_number_r - 30'd1));
    assign bresp_err_s = mst_axi_bvalid && (mst_axi_bresp != 2'b00);
    assign busy_s      = (state_r != S_IDLE) || (outstanding_r != {OUT_W{1'b0}})
                         || (fifo_cnt_r != {CNT_W{1'b0}});

    // configuration, enable and draining registers
    always_ff @(posedge clk) begin
        if (rst) begin
            start_addr_r   <= {ADDR_WIDTH{1'b0}};
            words_number_r <= 30'd0;
            enable_r       <= 1'b0;
            draining_r     <= 1'b0;
        end else begin
            if (wr_start_s) start_addr_r <= ctrl_writedata[ADDR_WIDTH-1:0];
            if (wr_words_s) words_number_r <= ctrl_writedata[29:0];
            if (wr_ctrl_s) enable_r <= ctrl_writedata[0];
            if (enable_fall_s) begin
                draining_r <= 1'b1;
            end else if (drain_done_s) begin
                draining_r <= 1'b0;
            end else begin
                draining_r <= draining_r;
            end
        end
    end

    // sticky error flags, cleared by writing ones to the status register
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sop_r   <= 1'b0;
            err_eop_r   <= 1'b0;
            err_bresp_r <= 1'b0;
        end else begin
            err_sop_r   <= (err_sop_r   && !(wr_status_s && ctrl_writedata[1])) || sop_err_s;
            err_eop_r   <= (err_eop_r   && !(wr_status_s && ctrl_writedata[2])) || eop_err_s;
            err_bresp_r <= (err_bresp_r && !(wr_status_s && ctrl_writedata[3])) || bresp_err_s;
        end
    end

    // frame synchronisation and word position within the frame
    always_ff @(posedge clk) begin
        if (rst) begin
            synced_r    <= 1'b0;
            frame_cnt_r <= 30'd0;
        end else if (drain_done_s) begin
            synced_r    <= 1'b0;
            frame_cnt_r <= 30'd0;
        end else if (push_s) begin
            synced_r    <= 1'b1;
            frame_cnt_r <= (word_idx_s == (words_number_r - 30'd1)) ? 30'd0 : (word_idx_s + 30'd1);
        end else begin
            synced_r    <= synced_r;
            frame_cnt_r <= frame_cnt_r;
        end
    end

    // FIFO storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r] <= st_data;
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk) begin
        if (rst || flush_s) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            fifo_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            case ({push_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CNT_W'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CNT_W'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
        end
    end

    // count of AW bursts whose B response is still pending
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= {OUT_W{1'b0}};
        end else begin
            case ({aw_fire_s, mst_axi_bvalid})
                2'b10:   outstanding_r <= outstanding_r + OUT_W'(1);
                2'b01:   outstanding_r <= (outstanding_r != {OUT_W{1'b0}}) ? outstanding_r - OUT_W'(1) : outstanding_r;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // burst address walks the frame region and wraps after its last burst
    always_ff @(posedge clk) begin
        if (rst) begin
            curr_addr_r    <= {ADDR_WIDTH{1'b0}};
            issued_words_r <= 30'd0;
        end else if (wr_start_s) begin
            curr_addr_r    <= ctrl_writedata[ADDR_WIDTH-1:0];
            issued_words_r <= 30'd0;
        end else if (enable_rise_s || drain_done_s) begin
            curr_addr_r    <= start_addr_r;
            issued_words_r <= 30'd0;
        end else if (aw_fire_s) begin
            if ((issued_words_r + BURST_WORDS) == words_number_r) begin
                curr_addr_r    <= start_addr_r;
                issued_words_r <= 30'd0;
            end else begin
                curr_addr_r    <= curr_addr_r + BURST_BYTES;
                issued_words_r <= issued_words_r + BURST_WORDS;
            end
        end else begin
            curr_addr_r    <= curr_addr_r;
            issued_words_r <= issued_words_r;
        end
    end

    // write FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // write FSM next-state: a burst starts only with a full burst buffered
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if ((enable_r || draining_r) && (fifo_cnt_r >= BURST_CNT) && (outstanding_r < MAX_OUT)) begin
                    state_next_s = S_AW;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_AW: begin
                if (mst_axi_awready) begin
                    state_next_s = S_DATA;
                end else begin
                    state_next_s = S_AW;
                end
            end
            S_DATA: begin
                if (w_last_fire_s) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DATA;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // write FSM outputs: valids held from state until their handshake
    always_comb begin
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        case (state_r)
            S_AW:    awvalid_s = 1'b1;
            S_DATA:  wvalid_s  = 1'b1;
            default: begin
                awvalid_s = 1'b0;
                wvalid_s  = 1'b0;
            end
        endcase
    end

    // beat position within the current W burst
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_r <= 8'd0;
        end else if (w_fire_s) begin
            beat_r <= (beat_r == LAST_BEAT) ? 8'd0 : (beat_r + 8'd1);
        end else begin
            beat_r <= beat_r;
        end
    end

    // register read multiplexer; unmapped addresses read as zero
    always_comb begin
        rd_mux_s = 32'd0;
        case (ctrl_address)
            5'h00:   rd_mux_s = 32'(start_addr_r);
            5'h04:   rd_mux_s = {2'b00, words_number_r};
            5'h08:   rd_mux_s = {31'd0, enable_r};
            5'h0C:   rd_mux_s = {28'd0, err_bresp_r, err_eop_r, err_sop_r, busy_s};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // two-cycle read: stall in the first cycle, return data in the second
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_phase_r <= 1'b0;
            readdata_r <= 32'd0;
        end else if (ctrl_read && !rd_phase_r) begin
            rd_phase_r <= 1'b1;
            readdata_r <= rd_mux_s;
        end else begin
            rd_phase_r <= 1'b0;
            readdata_r <= readdata_r;
        end
    end

    assign st_ready         = st_ready_s;
    assign mst_axi_awid     = 4'h0;
    assign mst_axi_awaddr   = curr_addr_r;
    assign mst_axi_awlen    = LAST_BEAT;
    assign mst_axi_awsize   = 3'b010;
    assign mst_axi_awburst  = 2'b01;
    assign mst_axi_awlock   = 1'b0;
    assign mst_axi_awcache  = 4'h0;
    assign mst_axi_awprot   = 3'b000;
    assign mst_axi_awqos    = 4'h0;
    assign mst_axi_awvalid  = awvalid_s;
    assign mst_axi_wdata    = fifo_mem_r[rd_ptr_r];
    assign mst_axi_wstrb    = 4'hF;
    assign mst_axi_wlast    = wvalid_s && (beat_r == LAST_BEAT);
    assign mst_axi_wvalid   = wvalid_s;
    assign mst_axi_bready   = 1'b1;
    assign ctrl_readdata    = readdata_r;
    assign ctrl_response    = 2'b00;
    assign ctrl_waitrequest = ctrl_read && !rd_phase_r;

endmodule

// File: tb/tb_stream_to_axi_dma.sv
// tb_stream_to_axi_dma
// Random AXI/stream timing around stream_to_axi_dma. A frame-level reference
// model turns accepted stream words into expected burst addresses and beat
// data; a monitor pops and compares them as the DUT presents AW and W beats.
module tb_stream_to_axi_dma;
    localparam int AW_W  = 24;
    localparam int BS    = 64;
    localparam int MO    = 2;
    localparam int FD    = 128;
    localparam int WORDS = 128;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [31:0] st_data = 32'd0;
    logic st_valid = 1'b0, st_startofpacket = 1'b0, st_endofpacket = 1'b0, st_ready;
    logic [3:0] mst_axi_awid, mst_axi_awcache, mst_axi_awqos, mst_axi_wstrb;
    logic [AW_W-1:0] mst_axi_awaddr;
    logic [7:0] mst_axi_awlen;
    logic [2:0] mst_axi_awsize, mst_axi_awprot;
    logic [1:0] mst_axi_awburst;
    logic mst_axi_awlock, mst_axi_awvalid, mst_axi_wlast, mst_axi_wvalid, mst_axi_bready;
    logic mst_axi_awready = 1'b0, mst_axi_wready = 1'b0, mst_axi_bvalid = 1'b0;
    logic [31:0] mst_axi_wdata;
    logic [3:0] mst_axi_bid = 4'h0;
    logic [1:0] mst_axi_bresp = 2'b00;
    logic [4:0] ctrl_address = 5'h00;
    logic ctrl_read = 1'b0, ctrl_write = 1'b0;
    logic [31:0] ctrl_writedata = 32'd0, ctrl_readdata;
    logic [3:0] ctrl_byteenable = 4'hF;
    logic [1:0] ctrl_response;
    logic ctrl_waitrequest;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0]     exp_data_q[$];
    logic [AW_W-1:0] exp_addr_q[$];
    bit              m_synced = 1'b0;
    int              m_pos = 0, m_partial = 0, m_burst = 0;
    logic [AW_W-1:0] m_start = '0;
    logic [3:0]      exp_err = 4'h0;

    // monitor / AXI responder state
    int   out_m = 0, aw_total = 0, w_bursts = 0, w_beat = 0, b_pending = 0;
    bit   b_hold = 1'b0, prev_aw_wait = 1'b0, prev_w_wait = 1'b0;
    logic [1:0] b_resp_val = 2'b00;

    stream_to_axi_dma #(.ADDR_WIDTH(AW_W), .BURST_SIZE(BS), .MAX_OUTSTANDING_TR(MO), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .st_data(st_data), .st_valid(st_valid), .st_startofpacket(st_startofpacket),
        .st_endofpacket(st_endofpacket), .st_ready(st_ready),
        .mst_axi_awid(mst_axi_awid), .mst_axi_awaddr(mst_axi_awaddr), .mst_axi_awlen(mst_axi_awlen),
        .mst_axi_awsize(mst_axi_awsize), .mst_axi_awburst(mst_axi_awburst), .mst_axi_awlock(mst_axi_awlock),
        .mst_axi_awcache(mst_axi_awcache), .mst_axi_awprot(mst_axi_awprot), .mst_axi_awqos(mst_axi_awqos),
        .mst_axi_awvalid(mst_axi_awvalid), .mst_axi_awready(mst_axi_awready),
        .mst_axi_wdata(mst_axi_wdata), .mst_axi_wstrb(mst_axi_wstrb), .mst_axi_wlast(mst_axi_wlast),
        .mst_axi_wvalid(mst_axi_wvalid), .mst_axi_wready(mst_axi_wready),
        .mst_axi_bid(mst_axi_bid), .mst_axi_bresp(mst_axi_bresp), .mst_axi_bvalid(mst_axi_bvalid),
        .mst_axi_bready(mst_axi_bready),
        .ctrl_address(ctrl_address), .ctrl_read(ctrl_read), .ctrl_readdata(ctrl_readdata),
        .ctrl_response(ctrl_response), .ctrl_write(ctrl_write), .ctrl_writedata(ctrl_writedata),
        .ctrl_byteenable(ctrl_byteenable), .ctrl_waitrequest(ctrl_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // frame-level model of what an accepted stream word means
    task automatic model_accept(input logic [31:0] d, input bit sop, input bit eop);
        if (!m_synced && sop) begin
            m_synced = 1'b1;
            m_pos = 0;
        end
        if (m_synced) begin
            if (sop && m_pos != 0) exp_err[1] = 1'b1;
            if (eop && m_pos != WORDS - 1) exp_err[2] = 1'b1;
            exp_data_q.push_back(d);
            m_partial++;
            if (m_partial == BS) begin
                exp_addr_q.push_back(AW_W'(int'(m_start) + m_burst * BS * 4));
                m_burst = (m_burst + 1) % (WORDS / BS);
                m_partial = 0;
            end
            m_pos = (m_pos + 1) % WORDS;
        end
    endtask

    // disable drops the unfinished burst and restarts the frame
    task automatic model_disable();
        repeat (m_partial) void'(exp_data_q.pop_back());
        m_partial = 0;
        m_synced = 1'b0;
        m_pos = 0;
        m_burst = 0;
    endtask

    // monitor: samples on the falling edge, between drive points
    always @(negedge clk) begin
        if (!rst) begin
            if (st_valid && st_ready) model_accept(st_data, st_startofpacket, st_endofpacket);
            if (mst_axi_bvalid) begin
                out_m--;
                if (mst_axi_bresp != 2'b00) exp_err[3] = 1'b1;
            end
            if (prev_aw_wait) check("awvalid_hold", 32'(mst_axi_awvalid), 32'd1);
            prev_aw_wait = mst_axi_awvalid && !mst_axi_awready;
            if (mst_axi_awvalid && mst_axi_awready) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL awaddr_unexpected: got 0x%0h with none expected", mst_axi_awaddr);
                end else begin
                    check("awaddr", 32'(mst_axi_awaddr), 32'(exp_addr_q.pop_front()));
                end
                check("awlen", 32'(mst_axi_awlen), 32'(BS - 1));
                check("awsize_burst", {27'd0, mst_axi_awsize, mst_axi_awburst}, {27'd0, 3'b010, 2'b01});
                aw_total++;
                out_m++;
                check("outstanding_max", 32'(out_m <= MO), 32'd1);
            end
            if (prev_w_wait) check("wvalid_hold", 32'(mst_axi_wvalid), 32'd1);
            prev_w_wait = mst_axi_wvalid && !mst_axi_wready;
            if (mst_axi_wvalid && mst_axi_wready) begin
                if (w_beat == 0) check("w_after_aw", 32'(aw_total > w_bursts), 32'd1);
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wdata_unexpected: got 0x%08h with none expected", mst_axi_wdata);
                end else begin
                    check("wdata", mst_axi_wdata, exp_data_q.pop_front());
                end
                check("wlast", 32'(mst_axi_wlast), 32'(w_beat == BS - 1));
                check("wstrb", 32'(mst_axi_wstrb), 32'hF);
                if (w_beat == BS - 1) begin
                    w_beat = 0;
                    w_bursts++;
                    b_pending++;
                end else begin
                    w_beat++;
                end
            end
        end
    end

    // random AW/W readiness
    initial begin
        forever begin
            @(posedge clk); #1;
            mst_axi_awready = ($urandom_range(0, 3) != 0);
            mst_axi_wready  = ($urandom_range(0, 4) != 0);
        end
    end

    // B responder: one response per completed burst after a random delay
    initial begin
        forever begin
            @(posedge clk); #1;
            if (!b_hold && b_pending > 0 && $urandom_range(0, 2) == 0) begin
                mst_axi_bvalid = 1'b1;
                mst_axi_bresp  = b_resp_val;
                b_pending--;
            end else begin
                mst_axi_bvalid = 1'b0;
                mst_axi_bresp  = 2'b00;
            end
        end
    end

    task automatic ctrl_wr(input logic [4:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        ctrl_address = a; ctrl_writedata = d; ctrl_write = 1'b1;
        @(posedge clk); #1;
        ctrl_write = 1'b0;
    endtask

    task automatic ctrl_rd(input logic [4:0] a, output logic [31:0] d, output int waits);
        @(posedge clk); #1;
        ctrl_address = a; ctrl_read = 1'b1;
        waits = 0; d = 32'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (ctrl_waitrequest) begin
                waits++;
            end else begin
                d = ctrl_readdata;
                break;
            end
        end
        @(posedge clk); #1;
        ctrl_read = 1'b0;
    endtask

    // present one word and hold it until accepted (bounded)
    task automatic send(input logic [31:0] d, input bit sop, input bit eop);
        bit acc;
        acc = 1'b0;
        st_data = d; st_startofpacket = sop; st_endofpacket = eop; st_valid = 1'b1;
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge clk);
            acc = st_ready;
            @(posedge clk); #1;
        end
        st_valid = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL st_timeout: word 0x%08h never accepted", d);
        end
    endtask

    task automatic send_frame(input logic [31:0] base, input int xsop, input int eop_at);
        for (int i = 0; i < WORDS; i++) send(base + 32'(i), (i == 0) || (i == xsop), i == eop_at);
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        int w;
        s = 32'd1;
        for (int i = 0; i < 400 && s[0]; i++) ctrl_rd(5'h0C, s, w);
        check("busy_clear", 32'(s[0]), 32'd0);
        check("data_q_empty", 32'(exp_data_q.size()), 32'd0);
        check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int waits, aw_base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_awvalid", 32'(mst_axi_awvalid), 32'd0);
        check("rst_wvalid", 32'(mst_axi_wvalid), 32'd0);
        check("rst_wlast", 32'(mst_axi_wlast), 32'd0);
        check("rst_st_ready", 32'(st_ready), 32'd0);
        check("rst_waitreq", 32'(ctrl_waitrequest), 32'd0);
        check("rst_readdata", ctrl_readdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        ctrl_rd(5'h0C, rd, waits);
        check("status_reset", rd, 32'd0);
        ctrl_wr(5'h00, 32'h0000_1234);
        ctrl_rd(5'h00, rd, waits);
        check("start_readback", rd, 32'h0000_1234);
        check("read_waits", 32'(waits), 32'd1);
        ctrl_rd(5'h10, rd, waits);
        check("unmapped_read", rd, 32'd0);

        // basic frames preceded by unsynced words
        ctrl_wr(5'h00, 32'h0000_1000);
        m_start = 24'h001000; m_burst = 0;
        ctrl_wr(5'h04, 32'(WORDS));
        ctrl_wr(5'h08, 32'd1);
        for (int i = 0; i < 10; i++) send(32'hBAD0_0000 + 32'(i), 1'b0, 1'b0);
        send_frame(32'hA000_0000, -1, WORDS - 1);
        send_frame(32'hA100_0000, -1, WORDS - 1);
        wait_idle();
        ctrl_rd(5'h0C, rd, waits);
        check("status_basic", rd, {28'd0, exp_err});

        // backpressure with B responses withheld
        b_hold = 1'b1;
        aw_base = aw_total;
        fork
            begin
                for (int f = 0; f < 3; f++) send_frame(32'hB000_0000 + 32'(f << 16), -1, WORDS - 1);
            end
            begin
                repeat (600) @(posedge clk);
                @(negedge clk);
                check("bp_aw_count", 32'(aw_total - aw_base), 32'(MO));
                check("bp_outstanding", 32'(out_m), 32'(MO));
                check("bp_st_ready", 32'(st_ready), 32'd0);
                @(posedge clk); #1;
                b_hold = 1'b0;
            end
        join
        wait_idle();

        // protocol errors and write-1-to-clear
        b_resp_val = 2'b10;
        send_frame(32'hC000_0000, 5, 100);
        wait_idle();
        b_resp_val = 2'b00;
        ctrl_rd(5'h0C, rd, waits);
        check("status_errors", rd, {28'd0, exp_err});
        ctrl_wr(5'h0C, 32'h0000_000E);
        exp_err = 4'h0;
        ctrl_rd(5'h0C, rd, waits);
        check("status_cleared", rd, 32'd0);

        // disable after 70 words, then re-enable
        for (int i = 0; i < 70; i++) send(32'hD000_0000 + 32'(i), i == 0, 1'b0);
        ctrl_wr(5'h08, 32'd0);
        model_disable();
        @(negedge clk);
        check("disabled_st_ready", 32'(st_ready), 32'd0);
        wait_idle();
        ctrl_wr(5'h08, 32'd1);
        send_frame(32'hE000_0000, -1, WORDS - 1);
        wait_idle();
        ctrl_rd(5'h0C, rd, waits);
        check("status_final", rd, {28'd0, exp_err});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // global time bound
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/stream_to_axi_dma.md
Name: stream_to_axi_dma

Overview:
Write-direction counterpart of the AXI read DMA. It accepts a 32-bit Avalon-ST pixel/word stream and writes it into memory as fixed-length AXI4 INCR write bursts. It fills a circular frame region of `words_number` words starting at `start_addr`. It is configured and monitored through a small Avalon-MM register file, and sits between the video input pipeline and the AXI interconnect in front of the frame buffer.

Parameters:
- ADDR_WIDTH, 24, width of AXI address and address registers.
- BURST_SIZE, 64, words per AXI burst (1..256).
- MAX_OUTSTANDING_TR, 2, maximum AW bursts issued with B response not yet received (>=1).
- FIFO_DEPTH, 128, internal word FIFO depth; power of 2, >= BURST_SIZE.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- st_data  in  32  stream data
- st_valid  in  1  stream valid
- st_startofpacket  in  1  first word of frame
- st_endofpacket  in  1  last word of frame
- st_ready  out  1  stream ready
- mst_axi_awid  out  4  constant 0
- mst_axi_awaddr  out  ADDR_WIDTH  burst address
- mst_axi_awlen  out  8  BURST_SIZE-1
- mst_axi_awsize  out  3  3'b010
- mst_axi_awburst  out  2  2'b01 (INCR)
- mst_axi_awlock  out  1  0
- mst_axi_awcache  out  4  0
- mst_axi_awprot  out  3  0
- mst_axi_awqos  out  4  0
- mst_axi_awvalid  out  1
- mst_axi_awready  in  1
- mst_axi_wdata  out  32
- mst_axi_wstrb  out  4  4'hF
- mst_axi_wlast  out  1
- mst_axi_wvalid  out  1
- mst_axi_wready  in  1
- mst_axi_bid  in  4  ignored
- mst_axi_bresp  in  2
- mst_axi_bvalid  in  1
- mst_axi_bready  out  1  constant 1
- ctrl_address  in  5  byte address
- ctrl_read  in  1
- ctrl_readdata  out  32
- ctrl_response  out  2  constant 2'b00
- ctrl_write  in  1
- ctrl_writedata  in  32
- ctrl_byteenable  in  4  ignored (full-word writes)
- ctrl_waitrequest  out  1

Behaviour:
- Clock and reset: single clock `clk`; `rst` is synchronous, active-high.
- Reset values: all registers 0. Outputs awvalid, wvalid, wlast, st_ready, ctrl_waitrequest and ctrl_readdata are 0. FIFO empty, FSM in IDLE, unsynced.
- Register map:
  - 0x00 start_addr (RW, ADDR_WIDTH bits).
  - 0x04 words_number (RW, 30 bits; must be a nonzero multiple of BURST_SIZE, otherwise behaviour is undefined).
  - 0x08 control (RW; bit0 = enable).
  - 0x0C status (bit0 busy RO; bit1 err_sop, bit2 err_eop, bit3 err_bresp: sticky, write-1-to-clear).
  - Unmapped addresses read 0; writes to them are ignored.
- Control bus timing:
  - Writes complete in the request cycle (waitrequest = 0).
  - Reads: waitrequest = 1 in the first cycle of `ctrl_read`. In the next cycle waitrequest = 0 and `ctrl_readdata` is valid. Then return to idle.
- Stream input:
  - `st_ready` = enable && !draining && FIFO not full.
  - After enable, the block is unsynced: accepted words are discarded until a word with sop arrives. That word is stored as word 0 and the block becomes synced.
- Frame word counter (synced only):
  - Increments on each accepted word; wraps to 0 after word `words_number-1`.
  - Accepted sop at counter != 0 sets err_sop.
  - Accepted eop at counter != `words_number-1` sets err_eop.
  - No realignment on errors; the data is stored anyway.
- Write FSM:
  - IDLE -> AW when enable && FIFO count >= BURST_SIZE && outstanding < MAX_OUTSTANDING_TR. Also taken while draining if FIFO count >= BURST_SIZE.
  - AW: awvalid = 1, awaddr = curr_addr. On awready go to DATA and increment outstanding.
  - DATA: wvalid = 1 with the FIFO head word. Each wready pops one word. wlast is asserted on beat BURST_SIZE-1. The wlast handshake returns to IDLE.
  - awvalid and wvalid never drop before their handshake.
  - The W burst never starts before its AW is accepted.
- Outstanding counter:
  - +1 on AW handshake, -1 on bvalid.
  - Simultaneous AW handshake and bvalid leaves it unchanged.
  - bresp != 0 sets err_bresp.
- Address generation:
  - curr_addr loads start_addr on a write to 0x00 and on the enable rising edge.
  - After each AW handshake: if the burst just issued is the last of the frame (burst index == words_number/BURST_SIZE - 1), curr_addr = start_addr; otherwise curr_addr += BURST_SIZE*4, modulo 2^ADDR_WIDTH.
- Disable mid-operation (enable 1 -> 0):
  - st_ready drops immediately.
  - Any burst in AW/DATA completes fully.
  - Leftover FIFO words (< BURST_SIZE) are flushed when FSM is IDLE.
  - Once outstanding reaches 0: frame counter cleared, unsynced, curr_addr = start_addr.
- busy = FSM != IDLE || outstanding != 0 || FIFO not empty.
- Reset mid-burst aborts everything immediately; AXI handshake integrity is not preserved.

Test Plan:
- Reset -> all valids, st_ready and waitrequest are 0; status reads 0. Reading 0x00 after writing 0x1234 returns 0x1234 with exactly one waitrequest cycle.
- Basic frame: BURST_SIZE=64, start=0x1000, words=128, enable, 2 frames of counting data with sop/eop -> AW addresses 0x1000, 0x1100, 0x1000, 0x1100. Each burst has 64 beats in stream order, wlast on beat 63, and no errors are set.
- Presync: 10 words without sop, then a frame -> the 10 words are dropped and the first AW carries the sop word at beat 0.
- Backpressure: random awready/wready/bvalid delays with bvalid withheld -> at most MAX_OUTSTANDING_TR=2 AWs issued; FIFO fills, st_ready=0, and no data is lost or duplicated.
- Errors: sop at word 5 -> err_sop; eop at word 100 of 128 -> err_eop; bresp=2'b10 -> err_bresp; writing 0xE to 0x0C clears all three.
- Disable after 70 words accepted -> burst 0 completes, the 6 leftover words are flushed, and busy goes to 0. Re-enable -> the next frame writes from 0x1000.
